// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses pll_reset, waits for a stable lock, then releases
// downstream channel resets one by one. Define PLL_RST_CTRL_SOFTRST_EN to add soft_rst_req.
module pll_rst_ctrl #(
   parameter int NUM_CH              = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 256,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int CH_STAGGER_CYCLES   = 8,
   parameter int MAX_RETRY           = 4
) (
   input  logic              clkin,
   input  logic              resetn,
`ifdef PLL_RST_CTRL_SOFTRST_EN
   input  logic              soft_rst_req,
`endif
   input  logic              pll_lock,
   output logic              pll_reset,
   output logic [NUM_CH-1:0] ch_rst_n,
   output logic              locked,
   output logic              fail,
   output logic [7:0]        relock_cnt
);

   function automatic int cw(int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

   localparam int STAG_MAX = (NUM_CH - 1) * CH_STAGGER_CYCLES;
   localparam int RW = cw(PLL_RST_CYCLES);
   localparam int SW = cw(LOCK_STABLE_CYCLES);
   localparam int TW = cw(LOCK_TIMEOUT_CYCLES);
   localparam int GW = cw(STAG_MAX);
   localparam int YW = cw(MAX_RETRY);

   localparam logic [RW-1:0] RST_LAST  = RW'(PLL_RST_CYCLES - 1);
   localparam logic [SW-1:0] STAB_N    = SW'(LOCK_STABLE_CYCLES);
   localparam logic [TW-1:0] TMO_N     = TW'(LOCK_TIMEOUT_CYCLES);
   localparam logic [GW-1:0] STAG_LAST = GW'(STAG_MAX);
   localparam logic [YW-1:0] RETRY_N   = YW'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_PLL_RST, ST_WAIT_LOCK, ST_RELEASE, ST_RUN, ST_FAIL
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        sync_q;
   logic              lock_s;
   logic              soft_req;
   logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
   logic [SW-1:0]     stab_q, stab_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [GW-1:0]     stag_q, stag_d;
   logic [YW-1:0]     retry_q, retry_d;
   logic [7:0]        relock_q, relock_d;
   logic              pll_reset_q, pll_reset_d;
   logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
   logic              locked_q, locked_d;
   logic              fail_q, fail_d;

`ifdef PLL_RST_CTRL_SOFTRST_EN
   assign soft_req = soft_rst_req;
`else
   assign soft_req = 1'b0;
`endif

   assign lock_s = sync_q[1];

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = '0;
      stab_d    = '0;
      tmo_d     = '0;
      stag_d    = '0;
      retry_d   = retry_q;
      relock_d  = relock_q;
      unique case (state_q)
         ST_PLL_RST: begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == RST_LAST) begin
               rst_cnt_d = '0;
               state_d   = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            stab_d = lock_s ? stab_q + 1'b1 : '0;
            tmo_d  = tmo_q + 1'b1;
            // a completed stable window wins over a same-cycle timeout
            if (stab_d == STAB_N) begin
               stab_d  = '0;
               tmo_d   = '0;
               state_d = ST_RELEASE;
            end else if (tmo_d == TMO_N) begin
               stab_d  = '0;
               tmo_d   = '0;
               retry_d = retry_q + 1'b1;
               state_d = (retry_d == RETRY_N) ? ST_FAIL : ST_PLL_RST;
            end
         end
         ST_RELEASE: begin
            if (!lock_s)                 state_d = ST_PLL_RST;
            else if (stag_q == STAG_LAST) state_d = ST_RUN;
            else                         stag_d  = stag_q + 1'b1;
         end
         ST_RUN: begin
            retry_d = '0;
            if (!lock_s) begin
               state_d = ST_PLL_RST;
               if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
            end
         end
         default: state_d = ST_FAIL;
      endcase

      if (soft_req) begin
         state_d   = ST_PLL_RST;
         rst_cnt_d = '0;
         stab_d    = '0;
         tmo_d     = '0;
         stag_d    = '0;
         retry_d   = '0;
         relock_d  = relock_q;
      end

      // outputs are registered from the next state so they line up with state_q
      pll_reset_d = (state_d == ST_PLL_RST);
      locked_d    = (state_d == ST_RUN);
      fail_d      = (state_d == ST_FAIL);
      for (int i = 0; i < NUM_CH; i++)
         ch_rst_n_d[i] = (state_d == ST_RUN) ||
                         ((state_d == ST_RELEASE) && (i * CH_STAGGER_CYCLES <= int'(stag_d)));
   end

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_PLL_RST;
         sync_q      <= '0;
         rst_cnt_q   <= '0;
         stab_q      <= '0;
         tmo_q       <= '0;
         stag_q      <= '0;
         retry_q     <= '0;
         relock_q    <= '0;
         pll_reset_q <= 1'b1;
         ch_rst_n_q  <= '0;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= {sync_q[0], pll_lock};
         rst_cnt_q   <= rst_cnt_d;
         stab_q      <= stab_d;
         tmo_q       <= tmo_d;
         stag_q      <= stag_d;
         retry_q     <= retry_d;
         relock_q    <= relock_d;
         pll_reset_q <= pll_reset_d;
         ch_rst_n_q  <= ch_rst_n_d;
         locked_q    <= locked_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_reset  = pll_reset_q;
   assign ch_rst_n   = ch_rst_n_q;
   assign locked     = locked_q;
   assign fail       = fail_q;
   assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Bench for pll_rst_ctrl: phase/time model checked every cycle plus directed
// literal checkpoints for reset, release staggering, glitch, timeout and relock.
module tb_pll_rst_ctrl;

   localparam int NUM_CH = 3;
   localparam int PRC    = 4;
   localparam int LSC    = 8;
   localparam int LTC    = 64;
   localparam int CSC    = 2;
   localparam int MR     = 3;

   localparam int PH_RST  = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_REL  = 2;
   localparam int PH_RUN  = 3;
   localparam int PH_FAIL = 4;

   logic              clkin, resetn, pll_lock;
   logic              pll_reset, locked, fail;
   logic [NUM_CH-1:0] ch_rst_n;
   logic [7:0]        relock_cnt;
`ifdef PLL_RST_CTRL_SOFTRST_EN
   logic              soft_rst_req;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   pll_rst_ctrl #(
      .NUM_CH(NUM_CH), .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
      .LOCK_TIMEOUT_CYCLES(LTC), .CH_STAGGER_CYCLES(CSC), .MAX_RETRY(MR)
   ) dut (
      .clkin(clkin),
      .resetn(resetn),
`ifdef PLL_RST_CTRL_SOFTRST_EN
      .soft_rst_req(soft_rst_req),
`endif
      .pll_lock(pll_lock),
      .pll_reset(pll_reset),
      .ch_rst_n(ch_rst_n),
      .locked(locked),
      .fail(fail),
      .relock_cnt(relock_cnt)
   );

   initial begin
      clkin = 1'b0;
      forever #5 clkin = ~clkin;
   end

   // model: current phase, cycles completed in it, lock history through two flops
   int m_ph = PH_RST, m_t = 0, m_stab = 0, m_tries = 0, m_relock = 0;
   bit m_s1 = 0, m_ls = 0;

   task automatic m_enter(int ph);
      m_ph = ph; m_t = 0; m_stab = 0;
   endtask

   task automatic m_step();
      bit ls;
      int rl;
      ls = m_ls; m_ls = m_s1; m_s1 = pll_lock;
      rl = m_relock;
      m_t++;
      case (m_ph)
         PH_RST:  if (m_t == PRC) m_enter(PH_WAIT);
         PH_WAIT: begin
            m_stab = ls ? m_stab + 1 : 0;
            if (m_stab == LSC) m_enter(PH_REL);
            else if (m_t == LTC) begin
               m_tries++;
               m_enter(m_tries == MR ? PH_FAIL : PH_RST);
            end
         end
         PH_REL:  if (!ls) m_enter(PH_RST);
                  else if (m_t > (NUM_CH - 1) * CSC) m_enter(PH_RUN);
         PH_RUN: begin
            m_tries = 0;
            if (!ls) begin
               if (m_relock < 255) m_relock++;
               m_enter(PH_RST);
            end
         end
         default: ;
      endcase
`ifdef PLL_RST_CTRL_SOFTRST_EN
      if (soft_rst_req) begin
         m_tries = 0; m_relock = rl; m_enter(PH_RST);
      end
`endif
   endtask

   function automatic logic [13:0] m_exp();
      logic [NUM_CH-1:0] ch;
      for (int i = 0; i < NUM_CH; i++)
         ch[i] = (m_ph == PH_RUN) || (m_ph == PH_REL && i * CSC <= m_t);
      return {m_ph == PH_RST, ch, m_ph == PH_RUN, m_ph == PH_FAIL, 8'(m_relock)};
   endfunction

   initial forever begin
      @(posedge clkin or negedge resetn);
      if (!resetn) begin
         m_enter(PH_RST); m_tries = 0; m_relock = 0; m_s1 = 0; m_ls = 0;
      end else m_step();
   end

   initial forever begin
      logic [13:0] got, exp;
      @(posedge clkin); #1;
      got = {pll_reset, ch_rst_n, locked, fail, relock_cnt};
      exp = m_exp();
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL model t=%0t {prst,ch,lk,fl,relock} got=%b required=%b", $time, got, exp);
      end
   end

   task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h required=%0h", nm, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkin); #1;
   endtask

   task automatic wait_locked(int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clkin);
         if (locked === 1'b1) break;
      end
      if (k == budget) chk("wait_locked_timeout", 16'd0, 16'd1);
   endtask

   task automatic wait_ch0(int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clkin);
         if (ch_rst_n[0] === 1'b1) break;
      end
      if (k == budget) chk("wait_ch0_timeout", 16'd0, 16'd1);
   endtask

   task automatic do_reset(logic lk);
      @(negedge clkin);
      resetn = 1'b0; pll_lock = lk;
      repeat (2) tick();
      @(negedge clkin);
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0; pll_lock = 1'b1;
`ifdef PLL_RST_CTRL_SOFTRST_EN
      soft_rst_req = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_pll_reset", 16'(pll_reset), 16'd1);
      chk("rst_ch",        16'(ch_rst_n),  16'd0);
      chk("rst_locked",    16'(locked),    16'd0);
      chk("rst_fail",      16'(fail),      16'd0);
      chk("rst_relock",    16'(relock_cnt), 16'd0);

      // lock high from the start: release at +12, stagger 001/011/111, RUN at +17
      @(negedge clkin); resetn = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         tick();
         case (k)
            3:  chk("seq_prst_hi", 16'(pll_reset), 16'd1);
            4:  chk("seq_prst_lo", 16'(pll_reset), 16'd0);
            11: chk("seq_ch_e11",  16'(ch_rst_n),  16'b000);
            12: chk("seq_ch_e12",  16'(ch_rst_n),  16'b001);
            14: chk("seq_ch_e14",  16'(ch_rst_n),  16'b011);
            16: begin chk("seq_ch_e16", 16'(ch_rst_n), 16'b111); chk("seq_lk_e16", 16'(locked), 16'd0); end
            17: chk("seq_lk_e17",  16'(locked),    16'd1);
            default: ;
         endcase
      end

      // lose lock in RUN: outputs drop on the third edge after the pin
      @(negedge clkin); pll_lock = 1'b0;
      tick(); tick();
      chk("drop_still_lk", 16'(locked), 16'd1);
      tick();
      chk("drop_lk",     16'(locked),     16'd0);
      chk("drop_ch",     16'(ch_rst_n),   16'b000);
      chk("drop_relock", 16'(relock_cnt), 16'd1);
      chk("drop_prst",   16'(pll_reset),  16'd1);
      @(negedge clkin); pll_lock = 1'b1;
      tick(); tick(); tick();
      chk("drop_pulse_hi", 16'(pll_reset), 16'd1);
      tick();
      chk("drop_pulse_lo", 16'(pll_reset), 16'd0);

      // lose lock during RELEASE after channel 0 is out
      wait_ch0(60);
      pll_lock = 1'b0;
      tick();
      chk("rel_ch_k1", 16'(ch_rst_n), 16'b001);
      tick();
      chk("rel_ch_k2", 16'(ch_rst_n), 16'b011);
      tick();
      chk("rel_ch_drop",  16'(ch_rst_n),   16'b000);
      chk("rel_relock",   16'(relock_cnt), 16'd1);
      chk("rel_prst",     16'(pll_reset),  16'd1);

      // saturation of relock_cnt
      for (int n = 0; n < 256; n++) begin
         @(negedge clkin); pll_lock = 1'b1;
         wait_locked(100);
         pll_lock = 1'b0;
         repeat (4) tick();
         if (n == 0) chk("sat_first", 16'(relock_cnt), 16'd2);
      end
      chk("sat_relock", 16'(relock_cnt), 16'd255);

      // one-cycle glitch at stable count 5 restarts the window: RELEASE at +18
      do_reset(1'b1);
      for (int k = 1; k <= 23; k++) begin
         tick();
         case (k)
            1:  chk("gl_relock_clr", 16'(relock_cnt), 16'd0);
            17: chk("gl_ch_e17", 16'(ch_rst_n), 16'b000);
            18: chk("gl_ch_e18", 16'(ch_rst_n), 16'b001);
            22: chk("gl_lk_e22", 16'(locked),   16'd0);
            23: chk("gl_lk_e23", 16'(locked),   16'd1);
            default: ;
         endcase
         @(negedge clkin);
         if (k + 1 == 8) pll_lock = 1'b0;
         if (k + 1 == 9) pll_lock = 1'b1;
      end

      // no lock: three pulses then FAIL
      do_reset(1'b0);
      for (int k = 1; k <= 204; k++) begin
         tick();
         case (k)
            4:   chk("to_p1_lo",  16'(pll_reset), 16'd0);
            67:  chk("to_e67",    16'(pll_reset), 16'd0);
            68:  chk("to_p2_hi",  16'(pll_reset), 16'd1);
            72:  chk("to_p2_lo",  16'(pll_reset), 16'd0);
            136: chk("to_p3_hi",  16'(pll_reset), 16'd1);
            140: chk("to_p3_lo",  16'(pll_reset), 16'd0);
            203: chk("to_nofail", 16'(fail),      16'd0);
            204: begin
               chk("to_fail",      16'(fail),      16'd1);
               chk("to_fail_prst", 16'(pll_reset), 16'd0);
               chk("to_fail_ch",   16'(ch_rst_n),  16'b000);
            end
            default: ;
         endcase
      end
      @(negedge clkin); pll_lock = 1'b1;
      repeat (30) tick();
      chk("fail_sticky", 16'(fail), 16'd1);

`ifdef PLL_RST_CTRL_SOFTRST_EN
      @(negedge clkin); soft_rst_req = 1'b1;
      tick();
      chk("soft_fail_clr", 16'(fail),      16'd0);
      chk("soft_prst",     16'(pll_reset), 16'd1);
      @(negedge clkin); soft_rst_req = 1'b0;
      wait_locked(100);
      @(negedge clkin); soft_rst_req = 1'b1;
      tick();
      chk("soft_run_ch",     16'(ch_rst_n),   16'b000);
      chk("soft_run_relock", 16'(relock_cnt), 16'd0);
      @(negedge clkin); soft_rst_req = 1'b0;
      repeat (4) tick();
`endif

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
